mux_func_unit: RTL and testbench

- Parametrised, programmable mux-based Boolean function generator.
- A 2^SEL_W-entry table selects, per select code, one of: constant 0, constant 1, a data input, or an inverted data input. This is a Shannon-expansion mux.
- The table is loaded at run time through a valid/ready config port; evaluations pass through a registered valid/ready datapath.
- Replaces hand-written fixed select-to-function mux blocks in the logic-function exercises.

---
 rtl/mux_func_unit_if.sv | 32 +++
 rtl/mux_func_unit.sv | 152 +++++++++++++++
 tb/tb_mux_func_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_func_unit_if.sv
// Config-load and evaluation handshake bundle for mux_func_unit.
// Every transfer completes on a rising clk edge where valid & ready are both high.
interface mux_func_unit_if #(
  parameter int SEL_W = 2,
  parameter int DIN_W = 2,
  parameter int IDX_W = 1
);
  localparam int ENTRY_W = 2 + IDX_W;

  logic               cfg_start;
  logic               cfg_valid;
  logic [ENTRY_W-1:0] cfg_entry;
  logic               cfg_ready;
  logic               cfg_done;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [DIN_W-1:0]   in_data;
  logic               out_valid;
  logic               out_f;
  logic               out_err;

  modport master (
    output cfg_start, cfg_valid, cfg_entry, in_valid, in_sel, in_data,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_f, out_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_entry, in_valid, in_sel, in_data,
    output cfg_ready, cfg_done, in_ready, out_valid, out_f, out_err
  );
endinterface

// File: rtl/mux_func_unit.sv
// Programmable Shannon-expansion mux: a 2^SEL_W-entry table maps each select code to 0, 1, d[idx] or ~d[idx].
// Optional SHADOW_CFG_EN: loads fill a shadow table that is copied to the active table on the last entry.
module mux_func_unit #(
  parameter int SEL_W = 2,
  parameter int DIN_W = 2,
  parameter int IDX_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_func_unit_if.slave       bus,
  output logic [1:0]           dbg_state_o
);
  localparam int ENTRY_W = 2 + IDX_W;
  localparam int DEPTH   = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   cnt_q;
  logic [ENTRY_W-1:0] tbl_q [DEPTH];
`ifdef SHADOW_CFG_EN
  logic [ENTRY_W-1:0] shd_q [DEPTH];
`endif
  logic               cfg_ready_q;
  logic               cfg_done_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               out_f_q;
  logic               out_err_q;

  logic               cfg_wr;
  logic               cfg_last;
  logic               in_acc;
  logic [ENTRY_W-1:0] sel_entry;
  logic               eval_f;
  logic               eval_err;

  // A cfg_start in the same cycle as cfg_valid restarts the load and drops the entry.
  assign cfg_wr   = bus.cfg_valid & cfg_ready_q & ~bus.cfg_start;
  assign cfg_last = cfg_wr & (cnt_q == SEL_W'(DEPTH - 1));
  assign in_acc   = bus.in_valid & in_ready_q;

  always_comb begin
    sel_entry = tbl_q[bus.in_sel];
    eval_f    = 1'b0;
    eval_err  = 1'b0;
    case (sel_entry[ENTRY_W-1 -: 2])
      2'b00:   eval_f = 1'b0;
      2'b01:   eval_f = 1'b1;
      default: begin
        // An index with no matching data input yields 0 and flags the error.
        eval_err = 1'b1;
        for (int k = 0; k < DIN_W; k++) begin
          if (int'(sel_entry[IDX_W-1:0]) == k) begin
            eval_err = 1'b0;
            eval_f   = bus.in_data[k] ^ sel_entry[ENTRY_W-2];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNCFG;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
      out_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
`ifdef SHADOW_CFG_EN
        shd_q[i] <= '0;
`endif
      end
    end else begin
      cfg_done_q  <= 1'b0;
      out_valid_q <= in_acc;
      if (in_acc) begin
        out_f_q   <= eval_f;
        out_err_q <= eval_err;
      end
      case (state_q)
        ST_UNCFG: begin
          if (bus.cfg_start) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.cfg_start) begin
            cnt_q <= '0;
          end else if (cfg_wr) begin
`ifdef SHADOW_CFG_EN
            shd_q[cnt_q] <= bus.cfg_entry;
`else
            tbl_q[cnt_q] <= bus.cfg_entry;
`endif
            if (cfg_last) begin
              state_q     <= ST_RUN;
              cnt_q       <= '0;
              cfg_ready_q <= 1'b0;
              cfg_done_q  <= 1'b1;
              in_ready_q  <= 1'b1;
`ifdef SHADOW_CFG_EN
              // Evaluations accepted on this edge still read the old active table.
              for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= (SEL_W'(i) == cnt_q) ? bus.cfg_entry : shd_q[i];
              end
`endif
            end else begin
              cnt_q <= cnt_q + SEL_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.cfg_start) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
`ifdef SHADOW_CFG_EN
            in_ready_q  <= 1'b1;
`else
            in_ready_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= ST_UNCFG;
          cfg_ready_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_err   = out_err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mux_func_unit.sv
// Bench for mux_func_unit: table-level reference model checked every cycle plus directed literal checks.
// A second instance with DIN_W=1 exercises the out-of-range index error.
module tb_mux_func_unit;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  int checks = 0;
  int errors = 0;

  mux_func_unit_if #(.SEL_W(2), .DIN_W(2), .IDX_W(1)) bus ();
  mux_func_unit_if #(.SEL_W(2), .DIN_W(1), .IDX_W(1)) bus2 ();

  mux_func_unit #(.SEL_W(2), .DIN_W(2), .IDX_W(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  mux_func_unit #(.SEL_W(2), .DIN_W(1), .IDX_W(1)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus2.slave),
    .dbg_state_o (dbg_state2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 = never started, 1 = loading, 2 = running.
  int         m_phase = 0;
  int         m_cnt   = 0;
  bit         m_has   = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_f     = 1'b0;
  logic       m_err   = 1'b0;
  logic       m_done  = 1'b0;
  logic [2:0] m_act [4] = '{default: 3'b000};
  logic [2:0] m_new [4] = '{default: 3'b000};
  logic [1:0] m_r;

  function automatic logic [1:0] ref_eval(input logic [2:0] ent, input logic [1:0] data, input int din_w);
    int idx;
    idx = int'(ent[0]);
    case (ent[2:1])
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: begin
        if (idx >= din_w) return 2'b10;
        return {1'b0, data[idx] ^ ent[1]};
      end
    endcase
  endfunction

  function automatic logic model_in_rdy();
`ifdef SHADOW_CFG_EN
    return (m_phase == 2) || (m_phase == 1 && m_has);
`else
    return (m_phase == 2);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_has = 1'b0;
      m_valid = 1'b0; m_f = 1'b0; m_err = 1'b0; m_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_act[i] = 3'b000;
        m_new[i] = 3'b000;
      end
    end else begin
      m_done  = 1'b0;
      m_valid = bus.in_valid && model_in_rdy();
      if (m_valid) begin
        m_r   = ref_eval(m_act[bus.in_sel], bus.in_data, 2);
        m_f   = m_r[0];
        m_err = m_r[1];
      end
      if (m_phase == 0) begin
        if (bus.cfg_start) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 1) begin
        if (bus.cfg_start) m_cnt = 0;
        else if (bus.cfg_valid) begin
`ifdef SHADOW_CFG_EN
          m_new[m_cnt] = bus.cfg_entry;
`else
          m_act[m_cnt] = bus.cfg_entry;
`endif
          m_cnt++;
          if (m_cnt == 4) begin
            m_phase = 2; m_cnt = 0; m_done = 1'b1; m_has = 1'b1;
`ifdef SHADOW_CFG_EN
            for (int i = 0; i < 4; i++) m_act[i] = m_new[i];
`endif
          end
        end
      end else begin
        if (bus.cfg_start) begin m_phase = 1; m_cnt = 0; end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("m_in_ready",  bus.in_ready,  model_in_rdy());
    chk("m_cfg_ready", bus.cfg_ready, (m_phase == 1));
    chk("m_cfg_done",  bus.cfg_done,  m_done);
    chk("m_out_valid", bus.out_valid, m_valid);
    chk("m_out_f",     bus.out_f,     m_f);
    chk("m_out_err",   bus.out_err,   m_err);
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_pulse();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Four entries packed {e3,e2,e1,e0}; cfg_done must appear only after the fourth.
  task automatic cfg_entries(input logic [11:0] ents);
    for (int k = 0; k < 4; k++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_entry = ents[3*k +: 3];
      tick();
      if (k < 3) chk("cfg_done_early", bus.cfg_done, 1'b0);
    end
    bus.cfg_valid = 1'b0;
    chk("cfg_done_pulse", bus.cfg_done, 1'b1);
    tick();
    chk("cfg_done_once", bus.cfg_done, 1'b0);
  endtask

  task automatic eval_chk(input logic [1:0] sel, input logic [1:0] data,
                          input logic exp_f, input logic exp_err, input string name);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk({name, "_f"},     bus.out_f,     exp_f);
    chk({name, "_err"},   bus.out_err,   exp_err);
  endtask

  // ---------------- directed sequence ----------------
  logic [11:0] ents2;
  logic [3:0]  exp2_f;
  logic [3:0]  exp2_err;

  initial begin
    rst_n = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_entry = '0;
    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0;
    bus2.cfg_start = 1'b0; bus2.cfg_valid = 1'b0; bus2.cfg_entry = '0;
    bus2.in_valid = 1'b0; bus2.in_sel = '0; bus2.in_data = '0;
    repeat (3) tick();
    chk("rst_in_ready",  bus.in_ready,  1'b0);
    chk("rst_cfg_ready", bus.cfg_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_f",     bus.out_f,     1'b0);
    rst_n = 1'b1;

    // Unconfigured: requests are ignored
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 2'b11;
    repeat (3) begin
      tick();
      chk("uncfg_no_out", bus.out_valid, 1'b0);
    end
    bus.in_valid = 1'b0;

    // Load {11,0},{10,1},{11,1},{00,0} and sweep with d=10
    cfg_pulse();
    chk("load_cfg_ready", bus.cfg_ready, 1'b1);
    cfg_entries({3'b000, 3'b111, 3'b101, 3'b110});
    chk("run_cfg_ready", bus.cfg_ready, 1'b0);
    eval_chk(2'd0, 2'b10, 1'b1, 1'b0, "sweep_s0");
    eval_chk(2'd1, 2'b10, 1'b1, 1'b0, "sweep_s1");
    eval_chk(2'd2, 2'b10, 1'b0, 1'b0, "sweep_s2");
    eval_chk(2'd3, 2'b10, 1'b0, 1'b0, "sweep_s3");
    eval_chk(2'd2, 2'b01, 1'b1, 1'b0, "sweep_s2_d01");
    tick();
    chk("idle_no_out", bus.out_valid, 1'b0);
    chk("idle_hold_f", bus.out_f, 1'b1);

    // Back-to-back requests: a result every cycle
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_sel  = 2'(i);
      bus.in_data = 2'(i >> 1);
      tick();
      chk("b2b_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_drain", bus.out_valid, 1'b0);

    // Restart after two entries; requests offered while loading
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 2'b00;
    cfg_pulse();
    bus.cfg_valid = 1'b1; bus.cfg_entry = 3'b011; tick();
    bus.cfg_entry = 3'b011; tick();
    bus.cfg_start = 1'b1; bus.cfg_entry = 3'b111; tick();
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
    chk("restart_no_done", bus.cfg_done, 1'b0);
    bus.in_valid = 1'b0;
    cfg_entries({3'b101, 3'b011, 3'b110, 3'b100});
    eval_chk(2'd0, 2'b01, 1'b1, 1'b0, "rl_s0");
    eval_chk(2'd1, 2'b01, 1'b0, 1'b0, "rl_s1");
    eval_chk(2'd2, 2'b01, 1'b1, 1'b0, "rl_s2");
    eval_chk(2'd3, 2'b10, 1'b1, 1'b0, "rl_s3");

    // cfg_start together with a request: evaluated against the current table
    bus.cfg_start = 1'b1;
    eval_chk(2'd1, 2'b00, 1'b1, 1'b0, "start_eval");
    bus.cfg_start = 1'b0;
    chk("start_eval_load", bus.cfg_ready, 1'b1);

    // Reset after one entry of a load
    bus.cfg_valid = 1'b1; bus.cfg_entry = 3'b010; tick();
    bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_in_ready",  bus.in_ready,  1'b0);
    chk("mid_rst_cfg_ready", bus.cfg_ready, 1'b0);
    chk("mid_rst_out_f",     bus.out_f,     1'b0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_done", bus.cfg_done, 1'b0);
    cfg_pulse();
    cfg_entries({4{3'b010}});
    for (int s = 0; s < 4; s++) eval_chk(2'(s), 2'(s), 1'b1, 1'b0, "const1");

    // Reload while streaming requests
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 2'b00;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
`ifdef SHADOW_CFG_EN
    chk("shd_start_f", bus.out_f, 1'b1);
`endif
    for (int k = 0; k < 4; k++) begin
      bus.cfg_valid = 1'b1; bus.cfg_entry = 3'b000;
      bus.in_sel = 2'(k);
      tick();
`ifdef SHADOW_CFG_EN
      chk("shd_in_ready", bus.in_ready, 1'b1);
      chk("shd_old_f",    bus.out_f,    1'b1);
`endif
    end
    bus.cfg_valid = 1'b0;
    tick();
    chk("stream_new_valid", bus.out_valid, 1'b1);
    chk("stream_new_f",     bus.out_f,     1'b0);
    bus.in_valid = 1'b0;
    tick();

    // DIN_W=1 instance: idx 1 is out of range
    ents2    = {3'b110, 3'b100, 3'b010, 3'b101};
    exp2_f   = 4'b0110;
    exp2_err = 4'b0001;
    bus2.cfg_start = 1'b1; tick(); bus2.cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus2.cfg_valid = 1'b1; bus2.cfg_entry = ents2[3*k +: 3];
      tick();
    end
    bus2.cfg_valid = 1'b0;
    chk("d1_done", bus2.cfg_done, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus2.in_valid = 1'b1; bus2.in_sel = 2'(k); bus2.in_data = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      chk("d1_valid", bus2.out_valid, 1'b1);
      chk("d1_f",     bus2.out_f,     exp2_f[k]);
      chk("d1_err",   bus2.out_err,   exp2_err[k]);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
